seq_shift_add_multiplier: RTL

SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

---
 rtl/seq_shift_add_multiplier.sv | 113 +++++++++++
 1 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one bit per cycle.
// Signed operands are multiplied as magnitudes and the sign is applied at the end.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic             carry;
  logic             neg;

  logic [WIDTH-1:0] m_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   sum;
  logic             load;

  // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1)
  always_comb begin
    m_mag = multiplicand;
    q_mag = multiplier;
    if (signed_mode && multiplicand[WIDTH-1])
      m_mag = -multiplicand;
    if (signed_mode && multiplier[WIDTH-1])
      q_mag = -multiplier;
  end

  // Conditional add of the multiplicand, keeping the carry out
  always_comb begin
    a_ext = {carry, a_reg};
    sum   = a_ext;
    if (q_reg[0])
      sum = a_ext + {1'b0, m_reg};
  end

  assign load = (state == S_IDLE) && start;
  assign busy = (state == S_RUN) || (state == S_FINISH);

  // Control: state, iteration counter, done pulse and product register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= S_FINISH;
        end
        S_FINISH: begin
          product <= neg ? -{a_reg, q_reg} : {a_reg, q_reg};
          done    <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operand load, then add-and-shift of {carry,A,Q}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      q_reg <= '0;
      m_reg <= '0;
      carry <= 1'b0;
      neg   <= 1'b0;
    end else if (load) begin
      a_reg <= '0;
      q_reg <= q_mag;
      m_reg <= m_mag;
      carry <= 1'b0;
      neg   <= signed_mode &
               (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
    end else if (state == S_RUN) begin
      a_reg <= sum[WIDTH:1];
      q_reg <= {sum[0], q_reg[WIDTH-1:1]};
      carry <= 1'b0;
    end
  end

endmodule
